// File: rtl/stimuli_obi_loader.sv
// Turns 64-bit byte-masked stimuli into up to two 32-bit OBI writes; 1 req cycle after handshake.
// Backpressure: stim_ready_o only in IDLE, one outstanding bus write, holds request until gnt_i.
module stimuli_obi_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stim_valid_i,
  output logic                  stim_ready_o,
  input  logic [ADDR_WIDTH-1:0] stim_addr_i,
  input  logic [63:0]           stim_data_i,
  input  logic [7:0]            stim_be_i,
  input  logic                  stim_last_i,
  input  logic [ADDR_WIDTH-1:0] stim_entry_i,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  input  logic                  rvalid_i,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] entry_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:3]   addr_q;
  logic [ADDR_WIDTH-1:0]   entry_in_q;
  logic [ADDR_WIDTH-1:0]   entry_q;
  logic [63:0]             data_q;
  logic [7:0]              be_q;
  logic                    last_q;
  logic                    half_q, half_d;
  logic                    err_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    hs;
  logic                    misaligned;
  logic                    finish;
  logic                    finish_last;
  logic [ADDR_WIDTH-1:0]   finish_entry;

  assign hs         = stim_valid_i && stim_ready_o;
  assign misaligned = (stim_addr_i[2:0] != 3'b000);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stimulus with nothing to write finishes straight from IDLE using the live inputs.
  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    finish       = 1'b0;
    finish_last  = 1'b0;
    finish_entry = entry_in_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          half_d = (stim_be_i[3:0] == 4'h0);
          if (misaligned || (stim_be_i == 8'h00)) begin
            finish       = 1'b1;
            finish_last  = stim_last_i;
            finish_entry = stim_entry_i;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (gnt_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rvalid_i) begin
          if (!half_q && (be_q[7:4] != 4'h0)) begin
            half_d  = 1'b1;
            state_d = REQ;
          end else begin
            finish      = 1'b1;
            finish_last = last_q;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (finish) begin
      state_d = finish_last ? DONE : IDLE;
    end
  end

  always_comb begin
    stim_ready_o = 1'b0;
    req_o        = 1'b0;
    done_o       = 1'b0;
    addr_o       = '0;
    be_o         = 4'h0;
    wdata_o      = 32'h0;
    case (state_q)
      IDLE: stim_ready_o = !rst_i;
      REQ: begin
        req_o   = 1'b1;
        addr_o  = {addr_q, half_q, 2'b00};
        be_o    = half_q ? be_q[7:4] : be_q[3:0];
        wdata_o = half_q ? data_q[63:32] : data_q[31:0];
      end
      DONE: done_o = 1'b1;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      entry_in_q <= '0;
      entry_q    <= '0;
      data_q     <= 64'h0;
      be_q       <= 8'h00;
      last_q     <= 1'b0;
      half_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      half_q <= half_d;
      if (hs) begin
        addr_q     <= stim_addr_i[ADDR_WIDTH-1:3];
        data_q     <= stim_data_i;
        be_q       <= stim_be_i;
        last_q     <= stim_last_i;
        entry_in_q <= stim_entry_i;
        if (misaligned) begin
          err_q <= 1'b1;
        end
      end
      if ((state_q == REQ) && gnt_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish && finish_last) begin
        entry_q <= finish_entry;
      end
    end
  end

  assign we_o       = 1'b1;
  assign err_o      = err_q;
  assign entry_o    = entry_q;
  assign wr_count_o = cnt_q;

endmodule

// File: doc/stimuli_obi_loader.md
# stimuli_obi_loader

Synthesizable consumer of preloader stimuli. Each stimulus is one 64-bit memory word with a byte-valid mask, produced from parsed S-records (`{addr, data}` pairs plus an entry point). The block turns each stimulus into at most two 32-bit OBI write transactions into on-chip memory. After the last stimulus it reports completion and the boot entry address. It sits between the stimulus source (testbench driver or debug/UART front end) and the system bus master port.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: bus and stimulus address width.
- `CNT_WIDTH`, 16: width of the bus-write counter.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `stim_valid_i`  in  1  stimulus valid.
- `stim_ready_o`  out  1  stimulus accepted when high together with `stim_valid_i`.
- `stim_addr_i`  in  ADDR_WIDTH  stimulus word address; must be 8-byte aligned.
- `stim_data_i`  in  64  data; byte k sits at `[8k+7:8k]`.
- `stim_be_i`  in  8  byte-valid mask; bytes whose bit is 0 are not written.
- `stim_last_i`  in  1  marks the final stimulus.
- `stim_entry_i`  in  ADDR_WIDTH  entry point, sampled only with the last stimulus.
- `req_o`  out  1  OBI request.
- `gnt_i`  in  1  OBI grant.
- `addr_o`  out  ADDR_WIDTH  OBI address, 4-byte aligned.
- `we_o`  out  1  write enable; always 1.
- `be_o`  out  4  OBI byte enables.
- `wdata_o`  out  32  OBI write data.
- `rvalid_i`  in  1  OBI response valid.
- `done_o`  out  1  load complete; sticky.
- `entry_o`  out  ADDR_WIDTH  captured entry point.
- `err_o`  out  1  sticky: a misaligned stimulus was dropped.
- `wr_count_o`  out  CNT_WIDTH  granted writes, saturating.

## Operation
State machine states:
- IDLE: `stim_ready_o` = 1.
  - On handshake, capture addr, data, be, last and entry into registers.
  - If `stim_addr_i[2:0] != 0`: set `err_o`, issue no writes, treat the stimulus as consumed, then apply the `last` rule below.
  - Otherwise select the first half that needs writing: low if `be[3:0] != 0`, else high if `be[7:4] != 0`.
  - If neither half needs writing, the stimulus completes immediately.
- REQ: `req_o` = 1.
  - Low half: `addr_o = {addr[AW-1:3], 3'b000}`, `be_o = be[3:0]`, `wdata_o = data[31:0]`.
  - High half: `addr_o` = low address + 4, `be_o = be[7:4]`, `wdata_o = data[63:32]`.
  - Outputs stay stable until `gnt_i`. On grant, increment `wr_count_o` (saturating at all-ones) and go to RSP.
- RSP: `req_o` = 0; wait for `rvalid_i`.
  - Then go to REQ for the high half if the current half was low and `be[7:4] != 0`.
  - Otherwise the stimulus completes.
- Stimulus completion: if captured `last` = 1, latch `entry_o` and go to DONE; else return to IDLE.
- DONE: `done_o` = 1, `stim_ready_o` = 0, `req_o` = 0. Exit only by reset.

Further rules:
- At most one outstanding transaction.
- `rvalid_i` outside RSP is ignored.
- `gnt_i` outside REQ is ignored.
- A misaligned last stimulus still ends in DONE, with the entry point latched.

## Timing
- Reset values: `stim_ready_o` = 0 while `rst_i` = 1; `req_o`, `done_o`, `err_o` = 0; `wr_count_o`, `entry_o`, `addr_o`, `be_o`, `wdata_o` = 0; `we_o` = 1; state = IDLE.
- `stim_ready_o` is 1 in the first cycle after reset deasserts.
- Handshake in cycle N → `req_o` high in N+1. No combinational path from `stim_valid_i` to `req_o`.
- Grant in cycle G → RSP from G+1. `rvalid_i` arrives no earlier than G+1.
- `rvalid_i` in cycle R → next REQ, IDLE or DONE in R+1.
- Full stimulus with zero-wait grants and responses: 5 cycles from handshake to the next `stim_ready_o`. Half stimulus: 3 cycles. `be` = 0: 1 cycle.
- `done_o` and `entry_o` are valid the cycle after the final `rvalid_i`, or the cycle after the handshake if no write was needed.
- Reset mid-transaction: the state returns to IDLE next cycle. Any in-flight request is abandoned; the interconnect is reset with the block.
- `wr_count_o` at max value stays at max.

## Test plan
- Aligned stimulus: addr 0x1000_0008, data 0x1122334455667788, be 0xFF → writes (0x1000_0008, be 0xF, 0x55667788) then (0x1000_000C, be 0xF, 0x11223344); `wr_count_o` = 2; next ready 5 cycles after the handshake.
- Partial masks:
  - be 0xF0 → one write at addr+4 only.
  - be 0x0C → one write at addr with `be_o` 0xC.
  - be 0x00 → no `req_o`, ready again the next cycle.
- Grant stall: hold `gnt_i` = 0 for 7 cycles → `addr_o`, `be_o`, `wdata_o` stable throughout and `req_o` held high; a single increment of `wr_count_o` on grant.
- Misaligned stimulus: addr 0x2000_0004 → `err_o` = 1, no bus activity; a following aligned stimulus is written normally and `err_o` stays 1.
- Last stimulus with entry 0x0000_0180 and be 0xFF → `done_o` = 1 one cycle after the second `rvalid_i`; `entry_o` = 0x180; `stim_ready_o` stays 0; a further valid stimulus is not accepted.
- Reset asserted while in RSP → next cycle all outputs are at reset values; after deassertion a fresh stimulus is accepted; `wr_count_o` restarts from 0.
